// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage: req/ack data-memory transactions for
//               loads/stores, single-cycle passthrough for ALU results.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_is_load,
    input  logic                      ex_is_store,
    input  logic [2:0]                ex_funct3,
    input  logic [DATA_WIDTH-1:0]     ex_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [3:0]                mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      wb_valid,
    output logic                      wb_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_fault
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [3:0]                mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                addr_lo_q, addr_lo_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      wb_valid_q, wb_valid_d;
    logic                      wb_we_q, wb_we_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic                      wb_fault_q, wb_fault_d;

    logic                      w_accept;
    logic                      w_is_load;
    logic                      w_is_store;
    logic                      w_is_mem;
    logic                      w_size_ok;
    logic                      w_misaligned;
    logic                      w_fault;
    logic [1:0]                w_addr_lo;
    logic [3:0]                w_be;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [DATA_WIDTH-1:0]     w_lane;
    logic [DATA_WIDTH-1:0]     w_load_data;

    assign ex_ready   = (state_q == IDLE);
    assign w_accept   = ex_valid && ex_ready;
    // A beat flagged both load and store is treated as a load.
    assign w_is_load  = ex_is_load;
    assign w_is_store = ex_is_store && !ex_is_load;
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_addr_lo  = ex_result[1:0];

    always_comb begin
        w_size_ok    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = '0;
        case (ex_funct3)
            3'b000, 3'b100: begin
                w_size_ok = 1'b1;
                w_be      = 4'b0001 << w_addr_lo;
                w_wdata   = {4{ex_store_data[7:0]}};
            end
            3'b001, 3'b101: begin
                w_size_ok    = 1'b1;
                w_misaligned = w_addr_lo[0];
                w_be         = w_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{ex_store_data[15:0]}};
            end
            3'b010: begin
                w_size_ok    = 1'b1;
                w_misaligned = (w_addr_lo != 2'b00);
                w_be         = 4'b1111;
                w_wdata      = ex_store_data;
            end
            default: begin
                w_size_ok = 1'b0;
            end
        endcase
        if (!w_is_store) begin
            w_wdata = '0;
        end
    end

    // Unsigned sizes (funct3[2]=1) exist only for loads.
    assign w_fault = w_is_mem && (!w_size_ok || w_misaligned || (w_is_store && ex_funct3[2]));

    assign w_lane = mem_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_fault_d  = wb_fault_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (!w_is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (ex_rd != '0);
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_result;
                        wb_fault_d = 1'b0;
                    end else if (w_fault) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_result;
                        wb_fault_d = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = w_is_store;
                        mem_addr_d  = {ex_result[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = w_be;
                        mem_wdata_d = w_wdata;
                        funct3_d    = ex_funct3;
                        addr_lo_d   = w_addr_lo;
                        rd_d        = ex_rd;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !mem_we_q && (rd_q != '0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = mem_we_q ? '0 : w_load_data;
                    wb_fault_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_fault_q  <= wb_fault_d;
        end
    end

    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_be          = mem_be_q;
    assign mem_wdata       = mem_wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_write_enable = wb_we_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign wb_fault        = wb_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed vector bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_write_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fault;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_is_load     (ex_is_load),
        .ex_is_store    (ex_is_store),
        .ex_funct3      (ex_funct3),
        .ex_result      (ex_result),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_write_enable(wb_write_enable),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_fault       (wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        exp_we;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
    endtask

    // One full memory transaction with ack after `dly` cycles of mem_req.
    task automatic mem_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int dly,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic e_we,
                          input logic [31:0] e_wb, input logic e_wbwe);
        logic stable;
        @(negedge clk);
        drive(ld, st, f3, addr, sd, rd);
        @(posedge clk); #1;
        chk({nm, " mem_req"}, {31'b0, mem_req}, 32'd1);
        chk({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, e_we});
        chk({nm, " mem_addr"}, mem_addr, e_addr);
        chk({nm, " mem_be"}, {28'b0, mem_be}, {28'b0, e_be});
        chk({nm, " mem_wdata"}, mem_wdata, e_wdata);
        chk({nm, " ex_ready busy"}, {31'b0, ex_ready}, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_be !== e_be ||
                mem_wdata !== e_wdata || mem_we !== e_we || wb_valid !== 1'b0)
                stable = 1'b0;
        end
        chk({nm, " held stable"}, {31'b0, stable}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk({nm, " wb_valid"}, {31'b0, wb_valid}, 32'd1);
        chk({nm, " wb_we"}, {31'b0, wb_write_enable}, {31'b0, e_wbwe});
        chk({nm, " wb_data"}, wb_data, e_wb);
        chk({nm, " wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        chk({nm, " wb_fault"}, {31'b0, wb_fault}, 32'd0);
        chk({nm, " mem_req drop"}, {31'b0, mem_req}, 32'd0);
        chk({nm, " ex_ready back"}, {31'b0, ex_ready}, 32'd1);
        @(posedge clk); #1;
        chk({nm, " wb pulse"}, {31'b0, wb_valid}, 32'd0);
    endtask

    initial begin
        logic seen;

        //            ld    st    f3      res           rd  we    fault
        vecs[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_0011, 5'd3, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 3'b000, 32'h0000_0022, 5'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 3'b000, 32'h0000_0033, 5'd7, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'b010, 32'h0000_1001, 5'd4, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 3'b011, 32'h0000_1000, 5'd4, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 3'b100, 32'h0000_1000, 5'd6, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 3'b001, 32'h0000_1001, 5'd9, 1'b0, 1'b1};

        rst = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd1);

        // Reset holds everything quiet even with a valid load presented.
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst ex_ready", {31'b0, ex_ready}, 32'd1);

        // Back-to-back single-cycle beats: passthrough then faults.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].res, 32'hFFFF_FFFF, vecs[i].rd);
            @(posedge clk); #1;
            chk($sformatf("v%0d wb_valid", i), {31'b0, wb_valid}, 32'd1);
            chk($sformatf("v%0d wb_we", i), {31'b0, wb_write_enable}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d wb_fault", i), {31'b0, wb_fault}, {31'b0, vecs[i].exp_fault});
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].res);
            chk($sformatf("v%0d wb_rd", i), {27'b0, wb_rd}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d mem_req", i), {31'b0, mem_req}, 32'd0);
        end
        @(negedge clk);
        ex_valid = 1'b0;

        // Spurious ack while idle.
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("spur mem_req", {31'b0, mem_req}, 32'd0);
        chk("spur wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("spur ex_ready", {31'b0, ex_ready}, 32'd1);

        mem_op("lb",  1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd2, 32'h80FF_FFFF, 2,
               32'h1000, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd2, 32'h80FF_FFFF, 2,
               32'h1000, 4'b1000, 32'h0, 1'b0, 32'h0000_0080, 1'b1);
        mem_op("sh",  1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 5'd8, 32'h0, 5,
               32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0, 1'b0);
        mem_op("sb",  1'b0, 1'b1, 3'b000, 32'h3001, 32'h1234_565A, 5'd0, 32'h0, 1,
               32'h3000, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0, 1'b0);
        mem_op("lh",  1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 5'd5, 32'h8001_7777, 0,
               32'h1000, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8001, 1'b1);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h1000, 32'h0, 5'd5, 32'h7777_9002, 1,
               32'h1000, 4'b0011, 32'h0, 1'b0, 32'h0000_9002, 1'b1);
        mem_op("lw both", 1'b1, 1'b1, 3'b010, 32'h4000, 32'hCAFE_F00D, 5'd11, 32'h1234_5678, 3,
               32'h4000, 4'b1111, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
        mem_op("lw x0", 1'b1, 1'b0, 3'b010, 32'h4004, 32'h0, 5'd0, 32'h0BAD_0BAD, 1,
               32'h4004, 4'b1111, 32'h0, 1'b0, 32'h0BAD_0BAD, 1'b0);

        // Reset while BUSY drops mem_req asynchronously and abandons the op.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd3);
        @(posedge clk); #1;
        chk("mid mem_req up", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid mem_req async", {31'b0, mem_req}, 32'd0);
        chk("mid mem_be async", {28'b0, mem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b0) seen = 1'b1;
        end
        mem_ack = 1'b0;
        chk("mid no wb", {31'b0, seen}, 32'd0);
        chk("mid ex_ready", {31'b0, ex_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of execution_unit.
- Consumes the execution result (ALU result or effective address), store data (rs2 value) and destination register.
- Runs a req/ack transaction with data memory for loads and stores, then presents one registered writeback beat that drives the register_file write port (write_enable, write_address, write_data).
- Non-memory results pass straight through with 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width; only 32 is supported, with byte lanes fixed at 4.
- ADDR_WIDTH, 32, memory byte-address width.
- REG_ADDR_WIDTH, 5, destination register index width; equals $clog2(REGISTER_DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  upstream beat valid.
- ex_ready  out  1  stage can accept a beat; equals (state==IDLE), combinational.
- ex_is_load  in  1  beat is a load.
- ex_is_store  in  1  beat is a store.
- ex_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_result  in  DATA_WIDTH  ALU result; used as byte address for memory ops.
- ex_store_data  in  DATA_WIDTH  rs2 value for stores.
- ex_rd  in  REG_ADDR_WIDTH  destination register.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WIDTH  word-aligned address; ex_result with [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_ack  in  1  transaction complete; read data valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read word.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_write_enable  out  1  register write strobe.
- wb_rd  out  REG_ADDR_WIDTH  write address.
- wb_data  out  DATA_WIDTH  write data.
- wb_fault  out  1  misaligned or illegal-size memory op.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_* all 0. Reset during BUSY drops mem_req immediately and abandons the transaction with no writeback.
- States: IDLE and BUSY. A beat is accepted when ex_valid && ex_ready is sampled.
- Load/store selection:
  - If both ex_is_load and ex_is_store are set, the beat is a load.
  - Memory op = ex_is_load || ex_is_store.
- Non-memory op:
  - Next cycle: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_write_enable=(ex_rd!=0).
  - State stays IDLE, giving throughput of 1 per cycle.
- Fault (memory op only):
  - Causes: funct3 not in {000,001,010,100,101}; halfword with addr[0]=1; word with addr[1:0]!=0; store with funct3 100 or 101.
  - No memory request is issued.
  - Next cycle: wb_valid=1, wb_fault=1, wb_write_enable=0, wb_data=ex_result (the faulting address).
  - State stays IDLE.
- Legal memory op:
  - On the next edge: state BUSY, mem_req=1, mem_we=is_store.
  - mem_addr, mem_be and mem_wdata are held stable until ack.
- Byte enables and store data:
  - Byte: mem_be = 1<<addr[1:0]; mem_wdata = {4{data[7:0]}}.
  - Halfword: mem_be = 0011 when addr[1]=0, else 1100; mem_wdata = {2{data[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = data.
  - Loads drive mem_be for the selected lanes and mem_wdata=0.
- BUSY:
  - Waits indefinitely for mem_ack.
  - On the edge where mem_ack=1 is sampled: mem_req<=0, state<=IDLE, and a writeback beat is registered (wb_valid=1 in the following cycle).
  - Load writeback: wb_data = lane extracted by addr[1:0], sign-extended for B/H and zero-extended for BU/HU; wb_write_enable=(rd!=0).
  - Store writeback: wb_write_enable=0, wb_data=0.
- mem_ack while mem_req=0 is ignored.
- Latency: a memory op accepted at edge T raises mem_req after T. If ack is sampled at edge A, then wb_valid is high in the cycle after A and ex_ready is high in that same cycle.
- wb_* hold their values between beats; only wb_valid is pulsed. wb_fault=0 on non-fault beats.

Test Plan:
- Reset: hold rst=0 with ex_valid=1 -> all outputs 0, no mem_req. Release rst -> ex_ready=1.
- ALU passthrough:
  - Three back-to-back non-memory beats, rd=3,0,7, results 0x11,0x22,0x33 -> wb_valid on 3 consecutive cycles.
  - wb_write_enable = 1,0,1; wb_data matches each result.
- LB sign extension: addr 0x1003, funct3 000, mem_rdata 0x80FFFFFF, ack after 2 cycles -> mem_addr 0x1000, mem_be 1000, wb_data 0xFFFFFF80. Repeat with funct3 100 -> wb_data 0x00000080.
- SH at addr 0x2002, store data 0x0000ABCD -> mem_we=1, mem_be 1100, mem_wdata 0xABCDABCD, held stable through a 5-cycle ack delay. Writeback beat has wb_write_enable=0.
- Faults:
  - LW at 0x1001 -> no mem_req; wb_fault=1, wb_data 0x1001.
  - funct3 011 load -> same fault response.
  - Spurious mem_ack while idle -> no effect.
- Reset mid-transaction: pull rst low while BUSY -> mem_req falls without waiting for a clock edge, and no wb_valid follows.
